// File: rtl/bessel_iir_multi_pkg.sv
// Shared widths, types and clamp limits for the multi-channel first-order Bessel IIR.
// Default build has the saturation flags disabled; define BESSEL_SAT_FLAG_EN to enable them.
package bessel_pkg;

   localparam int NUM_CH_D    = 4;
   localparam int ADC_WIDTH_D = 14;
   localparam int COEF_W_D    = 32;
   localparam int FRAC_BITS_D = 32;
   localparam int COEF_INIT_D = 1079;

   // Two guard bits above the clamp range keep the accumulator from wrapping.
   function automatic int acc_w(input int adc_width, input int frac_bits);
      return adc_width + frac_bits + 2;
   endfunction

   localparam int ACC_W_D = acc_w(ADC_WIDTH_D, FRAC_BITS_D);

   typedef logic signed [ADC_WIDTH_D-1:0] sample_t;
   typedef logic        [COEF_W_D-1:0]    coef_t;
   typedef logic signed [ACC_W_D-1:0]     acc_t;

   localparam acc_t ACC_HI = acc_t'((64'sd1 <<< (ADC_WIDTH_D - 1 + FRAC_BITS_D)) - 64'sd1);
   localparam acc_t ACC_LO = acc_t'(-(64'sd1 <<< (ADC_WIDTH_D - 1 + FRAC_BITS_D)));

endpackage

// File: rtl/bessel_iir_multi_if.sv
// Sample/coefficient/clear bus between the ADC capture side and the filter.
interface bessel_iir_multi_if
   import bessel_pkg::*;
#(
   parameter int NUM_CH    = NUM_CH_D,
   parameter int ADC_WIDTH = ADC_WIDTH_D,
   parameter int COEF_W    = COEF_W_D
);

   logic                          in_valid;
   logic [NUM_CH*ADC_WIDTH-1:0]   in_data;
   logic                          coef_wr;
   logic [COEF_W-1:0]             coef_in;
   logic                          clear;
   logic                          out_valid;
   logic [NUM_CH*ADC_WIDTH-1:0]   out_data;
   logic [NUM_CH-1:0]             sat_flag;

   modport master (
      output in_valid, in_data, coef_wr, coef_in, clear,
      input  out_valid, out_data, sat_flag
   );

   modport slave (
      input  in_valid, in_data, coef_wr, coef_in, clear,
      output out_valid, out_data, sat_flag
   );

endinterface

// File: rtl/bessel_iir_multi_ch.sv
// One channel of the Bessel IIR: S1 input sum, S2 coefficient multiply, S3 feedback/clamp.
// With BESSEL_SAT_FLAG_EN defined, o_sat is a sticky clamp indicator; otherwise it is tied low.
module bessel_iir_ch
   import bessel_pkg::*;
#(
   parameter int ADC_WIDTH = ADC_WIDTH_D,
   parameter int COEF_W    = COEF_W_D,
   parameter int FRAC_BITS = FRAC_BITS_D
)(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        i_clear,
   input  logic                        i_load,
   input  logic                        i_vld_p1,
   input  logic signed [ADC_WIDTH-1:0] i_x,
   input  logic        [COEF_W-1:0]    i_coef_p0,
   input  logic        [COEF_W-1:0]    i_coef_p1,
   output logic signed [ADC_WIDTH-1:0] o_out,
   output logic                        o_sat
);

   localparam int ACC_W  = acc_w(ADC_WIDTH, FRAC_BITS);
   localparam int SUM_W  = ADC_WIDTH + 1;
   localparam int PROD_W = ADC_WIDTH + COEF_W + 1;
   localparam int EXT_W  = ACC_W + 2;
   localparam int LIM_SH = ADC_WIDTH - 1 + FRAC_BITS;

   localparam logic signed [EXT_W-1:0] LIM_HI = $signed((EXT_W'(1) << LIM_SH) - EXT_W'(1));
   localparam logic signed [EXT_W-1:0] LIM_LO = $signed(EXT_W'(0) - (EXT_W'(1) << LIM_SH));

   function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [EXT_W-1:0] a);
      if (a > LIM_HI)
         sat_acc = LIM_HI[ACC_W-1:0];
      else if (a < LIM_LO)
         sat_acc = LIM_LO[ACC_W-1:0];
      else
         sat_acc = a[ACC_W-1:0];
   endfunction

   function automatic logic is_clamped(input logic signed [EXT_W-1:0] a);
      return (a > LIM_HI) || (a < LIM_LO);
   endfunction

   logic signed [ADC_WIDTH-1:0] r_x1;
   logic signed [ADC_WIDTH-1:0] r_out;
   logic signed [SUM_W-1:0]     w_sum;
   logic signed [SUM_W-1:0]     r_sum_p0;
   logic signed [PROD_W-1:0]    w_prod;
   logic signed [PROD_W-1:0]    r_prod_p1;
   logic signed [ACC_W-1:0]     r_y;
   logic signed [ACC_W-1:0]     w_y_int;
   logic signed [ACC_W-1:0]     w_y_next;
   logic signed [EXT_W-1:0]     w_fb;
   logic signed [EXT_W-1:0]     w_acc;

   // ---- S1: x + x[n-1], history advances only on accepted samples
   assign w_sum = $signed({i_x[ADC_WIDTH-1], i_x}) + $signed({r_x1[ADC_WIDTH-1], r_x1});

   always_ff @(posedge clk) begin
      if (reset)
         r_x1 <= '0;
      else if (i_clear)
         r_x1 <= '0;
      else if (i_load)
         r_x1 <= i_x;
   end

   always_ff @(posedge clk) begin
      r_sum_p0 <= w_sum;
   end

   // ---- S2: P = B * sum, B zero-extended so the coefficient stays unsigned
   assign w_prod = $signed({{(PROD_W-COEF_W){1'b0}}, i_coef_p0})
                 * $signed({{(PROD_W-SUM_W){r_sum_p0[SUM_W-1]}}, r_sum_p0});

   always_ff @(posedge clk) begin
      r_prod_p1 <= w_prod;
   end

   // ---- S3: y + P - 2B*floor(y), using the B that travelled with this sample
   assign w_y_int  = r_y >>> FRAC_BITS;
   assign w_fb     = $signed({{(EXT_W-COEF_W-1){1'b0}}, i_coef_p1, 1'b0})
                   * $signed({{(EXT_W-ACC_W){w_y_int[ACC_W-1]}}, w_y_int});
   assign w_acc    = $signed({{(EXT_W-ACC_W){r_y[ACC_W-1]}}, r_y})
                   + $signed({{(EXT_W-PROD_W){r_prod_p1[PROD_W-1]}}, r_prod_p1})
                   - w_fb;
   assign w_y_next = sat_acc(w_acc);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_y   <= '0;
         r_out <= '0;
      end else if (i_clear) begin
         r_y   <= '0;
      end else if (i_vld_p1) begin
         r_y   <= w_y_next;
         r_out <= w_y_next[FRAC_BITS+ADC_WIDTH-1:FRAC_BITS];
      end
   end

   assign o_out = r_out;

`ifdef BESSEL_SAT_FLAG_EN
   logic r_sat;

   always_ff @(posedge clk) begin
      if (reset || i_clear)
         r_sat <= 1'b0;
      else if (i_vld_p1 && is_clamped(w_acc))
         r_sat <= 1'b1;
   end

   assign o_sat = r_sat;
`else
   assign o_sat = 1'b0;
`endif

endmodule

// File: rtl/bessel_iir_multi.sv
// Multi-channel runtime-coefficient Bessel IIR low-pass: valid/coef pipeline, coefficient shadow, clear fan-out.
// Optional sticky saturation flags under BESSEL_SAT_FLAG_EN (tied to 0 when undefined).
module bessel_iir_multi
   import bessel_pkg::*;
#(
   parameter int                NUM_CH    = NUM_CH_D,
   parameter int                ADC_WIDTH = ADC_WIDTH_D,
   parameter int                COEF_W    = COEF_W_D,
   parameter int                FRAC_BITS = FRAC_BITS_D,
   parameter logic [COEF_W-1:0] COEF_INIT = COEF_W'(COEF_INIT_D)
)(
   input logic               clk,
   input logic               reset,
   bessel_iir_multi_if.slave bus
);

   logic                               r_vld_p0;
   logic                               r_vld_p1;
   logic                               r_vld_p2;
   logic [COEF_W-1:0]                  r_coef_shadow;
   logic [COEF_W-1:0]                  r_coef_active;
   logic [COEF_W-1:0]                  r_coef_p0;
   logic [COEF_W-1:0]                  r_coef_p1;
   logic [NUM_CH-1:0][ADC_WIDTH-1:0]   w_out;
   logic [NUM_CH-1:0]                  w_sat;

   always_ff @(posedge clk) begin
      if (reset || bus.clear) begin
         r_vld_p0 <= 1'b0;
         r_vld_p1 <= 1'b0;
         r_vld_p2 <= 1'b0;
      end else begin
         r_vld_p0 <= bus.in_valid;
         r_vld_p1 <= r_vld_p0;
         r_vld_p2 <= r_vld_p1;
      end
   end

   // Active follows shadow one cycle late, so the sample in the write cycle and the next one keep the old B.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_coef_shadow <= COEF_INIT;
         r_coef_active <= COEF_INIT;
      end else begin
         r_coef_active <= r_coef_shadow;
         if (bus.coef_wr)
            r_coef_shadow <= bus.coef_in;
      end
   end

   // ---- S1/S2 coefficient tags travel with the samples; valids qualify them
   always_ff @(posedge clk) begin
      r_coef_p0 <= r_coef_active;
      r_coef_p1 <= r_coef_p0;
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      bessel_iir_ch #(
         .ADC_WIDTH (ADC_WIDTH),
         .COEF_W    (COEF_W),
         .FRAC_BITS (FRAC_BITS)
      ) u_ch (
         .clk       (clk),
         .reset     (reset),
         .i_clear   (bus.clear),
         .i_load    (bus.in_valid),
         .i_vld_p1  (r_vld_p1),
         .i_x       (bus.in_data[c*ADC_WIDTH +: ADC_WIDTH]),
         .i_coef_p0 (r_coef_p0),
         .i_coef_p1 (r_coef_p1),
         .o_out     (w_out[c]),
         .o_sat     (w_sat[c])
      );
   end

   assign bus.out_valid = r_vld_p2;
   assign bus.out_data  = w_out;
   assign bus.sat_flag  = w_sat;

endmodule

// File: tb/tb_bessel_iir_multi.sv
// Randomised bench for bessel_iir_multi against an arithmetic reference model of the filter equation.
module tb_bessel_iir_multi;

   localparam int     NCH    = 4;
   localparam int     AW     = 14;
   localparam int     CW     = 32;
   localparam int     FB     = 32;
   localparam longint INIT_B = 1079;
   localparam longint Y_HI   = (longint'(1) <<< (AW - 1 + FB)) - 1;
   localparam longint Y_LO   = -(longint'(1) <<< (AW - 1 + FB));

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bessel_iir_multi_if #(.NUM_CH(NCH), .ADC_WIDTH(AW), .COEF_W(CW)) bus();

   bessel_iir_multi #(
      .NUM_CH(NCH), .ADC_WIDTH(AW), .COEF_W(CW), .FRAC_BITS(FB), .COEF_INIT(32'd1079)
   ) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
      end
   endtask

   // Reference model state
   typedef struct packed {
      int                   t;
      logic [63:0]          b;
      logic [NCH-1:0][63:0] sum;
   } smp_t;

   typedef struct packed {
      int          t;
      logic [63:0] v;
   } wr_t;

   smp_t     pend[$];
   wr_t      wr_q[$];
   longint   m_x1[NCH];
   longint   m_y[NCH];
   longint   m_out[NCH];
   bit       m_ov = 1'b0;
   bit [NCH-1:0] m_sat = '0;
   int       cyc_n = 0;

   // B for a sample taken in cycle t: last write issued two or more cycles earlier.
   function automatic longint coef_for(input int t);
      longint b = INIT_B;
      foreach (wr_q[i])
         if (wr_q[i].t <= t - 2) b = wr_q[i].v;
      return b;
   endfunction

   task automatic model_edge();
      smp_t   s;
      longint b, sm, acc, xv;
      logic signed [AW-1:0] xs;
      if (rst) begin
         pend.delete();
         wr_q.delete();
         for (int c = 0; c < NCH; c++) begin
            m_x1[c] = 0; m_y[c] = 0; m_out[c] = 0;
         end
         m_ov  = 1'b0;
         m_sat = '0;
      end else begin
         if (bus.coef_wr) wr_q.push_back('{cyc_n, {32'd0, bus.coef_in}});
         if (bus.clear) begin
            pend.delete();
            for (int c = 0; c < NCH; c++) begin
               m_x1[c] = 0; m_y[c] = 0;
            end
            m_ov  = 1'b0;
            m_sat = '0;
         end else begin
            m_ov = 1'b0;
            if (pend.size() > 0 && pend[0].t == cyc_n - 2) begin
               s = pend.pop_front();
               b = s.b;
               for (int c = 0; c < NCH; c++) begin
                  sm  = s.sum[c];
                  acc = m_y[c] + b * sm - 2 * b * (m_y[c] >>> FB);
                  if (acc > Y_HI || acc < Y_LO) begin
`ifdef BESSEL_SAT_FLAG_EN
                     m_sat[c] = 1'b1;
`endif
                     acc = (acc > Y_HI) ? Y_HI : Y_LO;
                  end
                  m_y[c]   = acc;
                  m_out[c] = acc >>> FB;
               end
               m_ov = 1'b1;
            end
            if (bus.in_valid) begin
               s.t = cyc_n;
               s.b = coef_for(cyc_n);
               for (int c = 0; c < NCH; c++) begin
                  xs       = bus.in_data[c*AW +: AW];
                  xv       = longint'(xs);
                  s.sum[c] = xv + m_x1[c];
                  m_x1[c]  = xv;
               end
               pend.push_back(s);
            end
         end
      end
      cyc_n++;
   endtask

   task automatic compare_all();
      check_val("out_valid", 64'(bus.out_valid), 64'(m_ov));
      for (int c = 0; c < NCH; c++)
         check_val($sformatf("out_ch%0d", c), 64'(bus.out_data[c*AW +: AW]), 64'(m_out[c][AW-1:0]));
      check_val("sat_flag", 64'(bus.sat_flag), 64'(m_sat));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   function automatic logic [NCH*AW-1:0] pack4(input int a, input int b, input int c, input int d);
      logic [AW-1:0] ta, tb, tc, td;
      ta = AW'(a); tb = AW'(b); tc = AW'(c); td = AW'(d);
      return {td, tc, tb, ta};
   endfunction

   task automatic conv_chk(input int c, input int exp);
      logic signed [AW-1:0] v;
      int d;
      v = bus.out_data[c*AW +: AW];
      d = int'(v) - exp;
      check_val($sformatf("conv_ch%0d", c), 64'(d >= -1 && d <= 1), 64'd1);
   endtask

   task automatic load_coef(input logic [CW-1:0] b);
      bus.coef_wr = 1'b1; bus.coef_in = b; bus.in_valid = 1'b0;
      tick();
      bus.coef_wr = 1'b0;
      tick();
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
   endtask

   logic [63:0] rd;

   initial begin
      bus.in_valid = 1'b1;
      bus.in_data  = pack4(123, -77, 4000, -4000);
      bus.coef_wr  = 1'b0;
      bus.coef_in  = '0;
      bus.clear    = 1'b0;
      rst          = 1'b1;

      // Reset held two cycles with traffic on the input
      tick(); tick();
      rst = 1'b0;
      bus.in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
         check_val("rst_out_data", 64'(bus.out_data), 64'd0);
         check_val("rst_sat", 64'(bus.sat_flag), 64'd0);
      end

      // Step response at B = 2^28
      load_coef(32'h1000_0000);
      bus.in_valid = 1'b1;
      bus.in_data  = pack4(1000, 0, 0, 0);
      tick(); check_val("lat_cyc1", 64'(bus.out_valid), 64'd0);
      tick(); check_val("lat_cyc2", 64'(bus.out_valid), 64'd0);
      tick(); check_val("lat_cyc3", 64'(bus.out_valid), 64'd1);
      check_val("step_first", 64'(bus.out_data[AW-1:0]), 64'd62);
      repeat (197) tick();
      conv_chk(0, 1000);

      // Channel isolation
      bus.in_valid = 1'b0; bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = pack4(1000, -1000, 0, 8191);
      repeat (150) tick();
      conv_chk(0, 1000); conv_chk(1, -1000); conv_chk(2, 0); conv_chk(3, 8191);

      // Coefficient reload in the same cycle as a sample
      bus.coef_wr = 1'b1; bus.coef_in = 32'h4000_0000;
      bus.in_data = pack4(-500, 300, 2000, -8000);
      tick();
      bus.coef_wr = 1'b0; bus.in_valid = 1'b0;
      tick();
      bus.in_valid = 1'b1;
      repeat (12) tick();

      // Randomised traffic with gaps, reloads, clears and occasional reset
      for (int i = 0; i < 1500; i++) begin
         rst          = ($urandom_range(0, 499) == 0);
         bus.clear    = ($urandom_range(0, 59) == 0);
         bus.coef_wr  = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 3) == 0) bus.coef_in = $urandom();
         else bus.coef_in = $urandom_range(32'h0400_0000, 32'h4000_0000);
         bus.in_valid = ($urandom_range(0, 9) < 7);
         rd = {$urandom(), $urandom()};
         bus.in_data = rd[NCH*AW-1:0];
         tick();
      end
      rst = 1'b0; bus.clear = 1'b0; bus.coef_wr = 1'b0; bus.in_valid = 1'b0;
      tick();

      // Positive saturation at maximum coefficient
      load_coef(32'hFFFF_FFFF);
      bus.in_valid = 1'b1;
      bus.in_data  = pack4(8191, 8191, 8191, 8191);
      repeat (40) tick();
      for (int c = 0; c < NCH; c++)
         check_val($sformatf("sat_hi_ch%0d", c), 64'(bus.out_data[c*AW +: AW]), 64'h1FFF);
      bus.in_valid = 1'b0;
      repeat (3) tick();
`ifdef BESSEL_SAT_FLAG_EN
      check_val("sat_sticky", 64'(bus.sat_flag), 64'hF);
`else
      check_val("sat_off", 64'(bus.sat_flag), 64'h0);
`endif

      // Negative full scale
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      check_val("sat_cleared", 64'(bus.sat_flag), 64'h0);
      bus.in_valid = 1'b1;
      bus.in_data  = pack4(-8192, -8192, -8192, -8192);
      repeat (40) tick();
      for (int c = 0; c < NCH; c++)
         check_val($sformatf("sat_lo_ch%0d", c), 64'(bus.out_data[c*AW +: AW]), 64'h2000);

      // Clear with samples in flight
      load_coef(32'h1000_0000);
      bus.in_valid = 1'b1;
      bus.in_data  = pack4(1000, 1000, 1000, 1000);
      repeat (20) tick();
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0; bus.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val("clr_no_valid", 64'(bus.out_valid), 64'd0);
      end
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick(); tick();
      check_val("clr_out_valid", 64'(bus.out_valid), 64'd1);
      check_val("clr_first", 64'(bus.out_data[AW-1:0]), 64'd62);
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
